// File: rtl/inst_refill_ctrl_pkg.sv
// Shared widths, state encoding and line-base masking for the instruction refill controller.
package inst_refill_ctrl_pkg;

  localparam int unsigned LINE_BITS   = 128;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned OFFSET_BITS = 4;

  // Byte-offset bits cleared to form a line base address.
  localparam logic [OFFSET_BITS-1:0] OFFSET_MASK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

endpackage

// File: rtl/inst_refill_ctrl.sv
// Instruction-cache miss handler: fetches a 16-byte line as four in-order word beats,
// assembles it and hands it to the cache with a one-cycle valid pulse.
module inst_refill_ctrl
  import inst_refill_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MAX_WAIT       = 255
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 miss_req,
  input  logic [ADDR_W-1:0]    miss_addr,
  input  logic                 abort,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ready,
  input  logic [WORD_BITS-1:0] mem_rdata,
  output logic [LINE_BITS-1:0] line_data,
  output logic [ADDR_W-1:0]    line_addr,
  output logic                 line_valid,
  output logic                 stall,
  output logic                 err
);

  localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK  = ~ADDR_W'(OFFSET_MASK);

  state_t                state_q;
  logic [ADDR_W-1:0]     base_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [WORD_BITS-1:0]  words_q [WORDS_PER_LINE];
  logic [LINE_BITS-1:0]  line_next_c;
  logic                  handshake_c;

  assign handshake_c = mem_req & mem_ready;

  // Fetch must freeze in the miss cycle itself, before the FSM has reacted.
  assign stall = (state_q != IDLE) | (miss_req & ~abort);

  // Completed line: earlier beats from the assembly registers, last beat straight from memory.
  always_comb begin
    line_next_c = '0;
    for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
      line_next_c[k*WORD_BITS +: WORD_BITS] = words_q[k];
    end
    line_next_c[int'(LAST_BEAT)*WORD_BITS +: WORD_BITS] = mem_rdata;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      line_data  <= '0;
      line_addr  <= '0;
      line_valid <= 1'b0;
      err        <= 1'b0;
      for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
        words_q[k] <= '0;
      end
    end else begin
      line_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_req && !abort) begin
            base_q   <= miss_addr & BASE_MASK;
            mem_addr <= miss_addr & BASE_MASK;
            beat_q   <= '0;
            wait_q   <= '0;
            mem_req  <= 1'b1;
            state_q  <= FETCH;
          end
        end

        FETCH: begin
          // Abort wins over a same-cycle handshake; that beat's data is dropped.
          if (abort) begin
            mem_req <= 1'b0;
            state_q <= IDLE;
          end else if (handshake_c) begin
            words_q[beat_q] <= mem_rdata;
            wait_q          <= '0;
            if (beat_q == LAST_BEAT) begin
              mem_req    <= 1'b0;
              line_data  <= line_next_c;
              line_addr  <= base_q;
              line_valid <= 1'b1;
              state_q    <= DELIVER;
            end else begin
              beat_q   <= beat_q + BEAT_W'(1);
              mem_addr <= base_q | ADDR_W'({beat_q + BEAT_W'(1), 2'b00});
            end
          end else if (wait_q == WAIT_LIMIT) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        DELIVER: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
